ssf_sample_feeder: RTL and testbench

- Responder end of the SSF sample-request interface.
- Buffers signed samples arriving from an upstream valid/ready stream.
- Presents the current sample on a held bus and advances to the next buffered sample on every cycle where the consumer's request code equals 1.
- Sits between the acquisition path and the SSF filter core. It replaces file-driven stimulus in hardware builds and counts starvation events.

---
 rtl/ssf_pkg.sv | 12 +
 rtl/ssf_sync_fifo.sv | 60 ++++++
 rtl/ssf_sample_feeder.sv | 99 +++++++++
 tb/tb_ssf_sample_feeder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ssf_pkg.sv
// Shared definitions for the SSF sample feeder and the SSF core.
package ssf_pkg;

  localparam logic [1:0] REQ_ADVANCE = 2'd1;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } head_state_e;

endpackage

// File: rtl/ssf_sync_fifo.sv
// Single-clock FIFO, count-based full/empty, no write-to-read bypass.
module ssf_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push, pop, full;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = wr_en_i && !full;
  assign pop     = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ssf_sample_feeder.sv
// SSF sample-request responder: buffers upstream samples and
// presents one held sample per advance request.
module ssf_sample_feeder
  import ssf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int LW = AW + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        req,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [LW-1:0]     level,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);

  head_state_e       state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              under_q, under_d;
  logic [CNT_W-1:0]  ucnt_q, ucnt_d;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              push, pop, adv, starve;

  assign adv     = (req == REQ_ADVANCE);
  assign s_ready = !rst && (fifo_cnt != CW'(DEPTH));
  assign push    = s_valid && s_ready;

  ssf_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (s_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    starve  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = PRIMED;
        end else if (adv) begin
          starve = 1'b1;
        end
      end
      PRIMED: begin
        if (adv) begin
          if (!fifo_empty) pop = 1'b1;
          else state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    sample_d = pop ? fifo_rd_data : sample_q;
    under_d  = under_q || starve;
    ucnt_d   = (starve && !(&ucnt_q)) ? ucnt_q + CNT_W'(1) : ucnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      sample_q <= '0;
      under_q  <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      under_q  <= under_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = (state_q == PRIMED);
  assign level        = LW'(fifo_cnt) + LW'(sample_valid);
  assign underrun     = under_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_ssf_sample_feeder.sv
// Directed bench for ssf_sample_feeder with hand-computed expectations.
module tb_ssf_sample_feeder;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  req;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic [5:0]  level;
  logic        underrun;
  logic [1:0]  underrun_cnt;

  int tests;
  int fails;

  ssf_sample_feeder #(
    .DATA_W (32),
    .DEPTH  (16),
    .CNT_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .req          (req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .level        (level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    req     = 2'd0;

    #2;
    chk("rst_ready_low", 32'(s_ready), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("idle_ready", 32'(s_ready), 32'd1);
    chk("idle_sample", sample_out, 32'd0);
    chk("idle_valid", 32'(sample_valid), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_under", 32'(underrun), 32'd0);
    repeat (6) step();

    // prime latency: two edges from accept to presentation
    s_valid = 1'b1;
    s_data  = 32'(-5);
    step();
    s_valid = 1'b0;
    chk("prime_e1_valid", 32'(sample_valid), 32'd0);
    chk("prime_e1_level", 32'(level), 32'd1);
    step();
    chk("prime_valid", 32'(sample_valid), 32'd1);
    chk("prime_sample", sample_out, 32'(-5));
    chk("prime_level", 32'(level), 32'd1);

    // drain -5 with nothing buffered: goes EMPTY without starvation
    req = 2'd1;
    step();
    req = 2'd0;
    chk("drain_valid", 32'(sample_valid), 32'd0);
    chk("drain_hold", sample_out, 32'(-5));
    chk("drain_under", 32'(underrun), 32'd0);

    // ordered advance
    s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = 32'(i);
      step();
    end
    s_valid = 1'b0;
    chk("ord_first", sample_out, 32'd1);
    chk("ord_level", 32'(level), 32'd4);
    req = 2'd1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("ord_seq", sample_out, 32'(i));
    end
    step();
    req = 2'd0;
    chk("ord_empty", 32'(sample_valid), 32'd0);
    chk("ord_hold4", sample_out, 32'd4);
    chk("ord_under", 32'(underrun), 32'd0);

    // ignored request codes
    s_valid = 1'b1;
    s_data  = 32'd7;
    step();
    s_valid = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0:       req = 2'd0;
        1:       req = 2'd2;
        default: req = 2'd3;
      endcase
      step();
      chk("ign_sample", sample_out, 32'd7);
    end
    req = 2'd0;
    chk("ign_level", 32'(level), 32'd1);
    chk("ign_valid", 32'(sample_valid), 32'd1);
    req = 2'd1;
    step();
    req = 2'd0;
    chk("ign_drain", 32'(sample_valid), 32'd0);

    // fill to DEPTH+1, then pop and write in the same cycles
    s_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      s_data = 32'(i);
      step();
    end
    s_data = 32'd17;
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd17);
    chk("full_head", sample_out, 32'd0);
    req = 2'd1;
    step();
    req = 2'd0;
    chk("full_pop_sample", sample_out, 32'd1);
    chk("full_pop_ready", 32'(s_ready), 32'd1);
    chk("full_pop_level", 32'(level), 32'd16);
    step();
    s_valid = 1'b0;
    chk("refill_level", 32'(level), 32'd17);
    chk("refill_ready", 32'(s_ready), 32'd0);
    req = 2'd1;
    for (int i = 2; i <= 17; i++) begin
      step();
      chk("full_order", sample_out, 32'(i));
    end
    step();
    req = 2'd0;
    chk("full_empty", 32'(sample_valid), 32'd0);
    chk("full_under", 32'(underrun), 32'd0);

    // starvation and saturation
    req = 2'd1;
    step();
    chk("starve_flag", 32'(underrun), 32'd1);
    chk("starve_cnt1", 32'(underrun_cnt), 32'd1);
    repeat (4) step();
    req = 2'd0;
    chk("starve_sat", 32'(underrun_cnt), 32'd3);
    chk("starve_valid", 32'(sample_valid), 32'd0);

    // three samples buffered, then async reset mid-cycle
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'(100 + i);
      step();
    end
    s_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_under", 32'(underrun), 32'd0);
    chk("arst_cnt", 32'(underrun_cnt), 32'd0);
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_sample", sample_out, 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(s_ready), 32'd1);
    repeat (2) step();
    chk("post_rst_valid", 32'(sample_valid), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
